neuron_mac_writeback: RTL and testbench
=======================================

# neuron_mac_writeback

Downstream datapath stage of the accelerator. Consumes the weight/input-neuron stream from the accelerator FSM, multiply-accumulates per output neuron, then rounds, saturates and applies ReLU. Presents each finished neuron, with its output-buffer address, on a valid/ready port toward the output BRAM. Tracks layer completion and signals back-pressure to the FSM.

## Interface
Parameters:
- DATA_W, 16, signed fixed-point width of weights, inputs and results
- FRAC_W, 8, fractional bits (Q8.8)
- ACC_W, 40, accumulator width
- ADDR_W, 16, output-buffer address width
- RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- layer_start  in  1  one-cycle pulse starting a layer
- BaseAddr_out  in  ADDR_W  first output address, sampled on layer_start
- total_output_neurons  in  16  neurons in layer, sampled on layer_start
- PE_enable  in  1  weight/in_data beat valid
- weight  in  DATA_W  signed weight
- in_data  in  DATA_W  signed input neuron
- neuron_done  in  1  closes current neuron; may coincide with last beat or stand alone
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_data  out  DATA_W  activated result
- out_addr  out  ADDR_W  write address of result
- busy  out  1  out_valid & ~out_ready; FSM must not assert neuron_done while high
- sat_flag  out  1  sticky: a result or the accumulator saturated this layer
- ovf_err  out  1  sticky: a result was dropped because the holding register was full
- layer_done  out  1  one-cycle pulse on acceptance of the Nth result

## Operation
- S1, every cycle: p1 <= weight*in_data (signed, 2*DATA_W), v1 <= PE_enable, d1 <= neuron_done.
- S2: acc <= (d2 ? 0 : acc) + (v1 ? sext(p1) : 0), saturating at ±(2^(ACC_W-1)-1) and setting sat_flag; d2 <= d1.
- S3, when d2: res = (acc + 2^(FRAC_W-1)) >>> FRAC_W, saturated to DATA_W signed (sets sat_flag on clip), then ReLU if RELU=1.
  - Holding register empty, or drained this cycle: load out_data, out_addr <= addr_cnt, out_valid <= 1, addr_cnt++.
  - Otherwise: drop result, set ovf_err; addr_cnt unchanged.
- Acceptance: clear out_valid unless reloaded the same cycle; done_cnt++. When done_cnt reaches total_output_neurons, pulse layer_done and reset done_cnt.
- layer_start:
  - Loads addr_cnt and count target.
  - Clears acc, v1, d1, d2, done_cnt, sat_flag and ovf_err.
  - A held result remains valid, and its acceptance is not counted toward the new layer.
- addr_cnt wraps modulo 2^ADDR_W.
- total_output_neurons = 0: layer_done never pulses.
- Reset: all outputs and state 0 immediately, regardless of clk; in-flight neuron lost.

## Timing
- neuron_done sampled at edge T:
  - Accumulator holds the final value after edge T+1.
  - out_valid high after edge T+2, i.e. 3 cycles after the neuron_done cycle.
- Back-to-back neurons: the next neuron's first beat may coincide with the previous neuron's neuron_done+1 cycle. The d2 clear guarantees no cross-talk, so throughput is one beat per cycle.
- out_data/out_addr stable while out_valid & ~out_ready.
- layer_done is registered, high the cycle after the accepting edge.

## Structure
- Package nn_pkg: DATA_W/FRAC_W/ACC_W defaults and the signed saturate function shared with the PE.
- Sub-module nn_round_sat: combinational round-half-up, arithmetic shift, DATA_W saturation and ReLU, with a saturation flag output.
- The top holds the S1/S2 pipeline, holding register, address/done counters and flags.

## Test plan
- Basic neuron: BaseAddr_out=0x0040, N=1. Four beats 0x0100×0x0200, neuron_done on the 4th beat → out_valid 3 cycles later, out_data=0x0800, out_addr=0x0040; layer_done pulses after out_ready.
- Sign/ReLU: one beat 0xFF00×0x0300 → out_data=0x0000 with RELU=1; 0xFD00 with RELU=0.
- Saturation/rounding:
  - Four beats 0x7FFF×0x7FFF → 0x7FFF, sat_flag=1.
  - Single beat 0x0001×0x0080 → 0x0001 (half rounds up).
- Back-pressure: N=3, three consecutive neurons with out_ready=0 → first held at 0x0040, busy=1, second dropped with ovf_err=1. Then out_ready=1 and a fresh neuron → address 0x0041; layer_done is not asserted until the third accepted result.
- Back-to-back: neuron A (1.0×1.0), then neuron B (2.0×1.0) starting the cycle after A's neuron_done, out_ready=1 → 0x0100 then 0x0200, no accumulation leakage.
- Reset mid-neuron: rst low during beat 2 → all outputs 0 without a clock edge. After release and layer_start, one beat 0x0100×0x0100 → 0x0100 at BaseAddr_out.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults and helpers for the neuron datapath.
//   NnDataW / NnFracW / NnAccW : default data, fraction and accumulator widths (Q8.8, 40-bit acc)
//   sat_signed()               : clamp a 64-bit signed value into a w-bit signed range
package nn_pkg;

    localparam int unsigned NnDataW = 16;
    localparam int unsigned NnFracW = 8;
    localparam int unsigned NnAccW  = 40;

    // sym = 1 gives the symmetric range +/-(2^(w-1)-1); sym = 0 gives the full two's-complement range.
    // w must be in 2..63.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned       w,
                                                      input logic              sym);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = sym ? -max_v : -max_v - 64'sd1;
        if (x > max_v) begin
            return max_v;
        end else if (x < min_v) begin
            return min_v;
        end
        return x;
    endfunction

endpackage

// File: rtl/nn_round_sat.sv
// nn_round_sat: combinational write-back conversion of an accumulator value.
//   acc_i : signed accumulator (ACC_W bits, FRAC_W fractional bits scaled like the products)
//   res_o : round-half-up, arithmetic shift by FRAC_W, saturate to DATA_W, optional ReLU
//   sat_o : high when the DATA_W saturation clipped the value
module nn_round_sat
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NnDataW,
    parameter int unsigned FRAC_W = NnFracW,
    parameter int unsigned ACC_W  = NnAccW,
    parameter int unsigned RELU   = 1
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] res_o,
    output logic                     sat_o
);

    logic signed [63:0] wide;
    logic signed [63:0] rounded;
    logic signed [63:0] clipped;

    always_comb begin
        // Widened to 64 bits so adding the half-LSB cannot wrap the accumulator range.
        wide    = 64'(acc_i) + (64'sd1 <<< (FRAC_W - 1));
        rounded = wide >>> FRAC_W;
        clipped = sat_signed(rounded, DATA_W, 1'b0);
        sat_o   = (clipped != rounded);
        res_o   = clipped[DATA_W-1:0];
        if ((RELU != 0) && res_o[DATA_W-1]) begin
            res_o = '0;
        end
    end

endmodule

// File: rtl/neuron_mac_writeback.sv
// neuron_mac_writeback: MAC pipeline plus write-back holding register for one output neuron stream.
//   clk, rst (async, active low)
//   layer_start, BaseAddr_out, total_output_neurons : layer setup, sampled on the start pulse
//   PE_enable, weight, in_data, neuron_done         : beat stream from the accelerator FSM
//   out_valid/out_ready/out_data/out_addr           : result port toward the output buffer
//   busy, sat_flag, ovf_err, layer_done             : status back to the FSM
module neuron_mac_writeback
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NnDataW,
    parameter int unsigned FRAC_W = NnFracW,
    parameter int unsigned ACC_W  = NnAccW,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RELU   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     layer_start,
    input  logic        [ADDR_W-1:0] BaseAddr_out,
    input  logic        [15:0]       total_output_neurons,
    input  logic                     PE_enable,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     neuron_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] out_data,
    output logic        [ADDR_W-1:0] out_addr,
    output logic                     busy,
    output logic                     sat_flag,
    output logic                     ovf_err,
    output logic                     layer_done
);

    logic signed [2*DATA_W-1:0] p1_q, p1_d;
    logic                       v1_q, v1_d, d1_q, d1_d, d2_q, d2_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       out_valid_q, out_valid_d;
    logic        [DATA_W-1:0]   out_data_q, out_data_d;
    logic        [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic        [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic        [15:0]         target_q, target_d;
    logic        [15:0]         done_cnt_q, done_cnt_d;
    logic                       stale_q, stale_d;
    logic                       sat_flag_q, sat_flag_d;
    logic                       ovf_err_q, ovf_err_d;
    logic                       layer_done_q, layer_done_d;

    logic signed [63:0] acc_ext, prod_ext, acc_sum, acc_sat;
    logic               acc_clip, load, drop, accept, count;
    logic [DATA_W-1:0]  res;
    logic               res_sat;

    nn_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W),
        .RELU   (RELU)
    ) u_round_sat (
        .acc_i (acc_q),
        .res_o (res),
        .sat_o (res_sat)
    );

    always_comb begin
        p1_d = (2*DATA_W)'(weight) * (2*DATA_W)'(in_data);
        v1_d = PE_enable & ~layer_start;
        d1_d = neuron_done & ~layer_start;
        d2_d = d1_q & ~layer_start;

        // d2 marks the cycle the finished sum is read out, so the next neuron restarts from 0.
        acc_ext  = d2_q ? 64'sd0 : 64'(acc_q);
        prod_ext = v1_q ? 64'(p1_q) : 64'sd0;
        acc_sum  = acc_ext + prod_ext;
        acc_sat  = sat_signed(acc_sum, ACC_W, 1'b1);
        acc_clip = (acc_sat != acc_sum);
        acc_d    = layer_start ? '0 : acc_sat[ACC_W-1:0];

        accept = out_valid_q & out_ready;
        load   = d2_q & ~layer_start & (~out_valid_q | out_ready);
        drop   = d2_q & ~layer_start & out_valid_q & ~out_ready;

        out_valid_d = load | (out_valid_q & ~out_ready);
        out_data_d  = load ? res : out_data_q;
        out_addr_d  = load ? addr_cnt_q : out_addr_q;

        addr_cnt_d = addr_cnt_q;
        if (layer_start) begin
            addr_cnt_d = BaseAddr_out;
        end else if (load) begin
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        end
        target_d = layer_start ? total_output_neurons : target_q;

        // A result still held across layer_start belongs to the old layer and is not counted.
        stale_d = stale_q;
        if (layer_start) begin
            stale_d = out_valid_q & ~out_ready;
        end else if (load) begin
            stale_d = 1'b0;
        end
        count = accept & ~stale_q & ~layer_start;

        done_cnt_d   = done_cnt_q;
        layer_done_d = 1'b0;
        if (layer_start) begin
            done_cnt_d = '0;
        end else if (count) begin
            if ((target_q != 16'd0) && (done_cnt_q + 16'd1 == target_q)) begin
                done_cnt_d   = '0;
                layer_done_d = 1'b1;
            end else begin
                done_cnt_d = done_cnt_q + 16'd1;
            end
        end

        sat_flag_d = layer_start ? 1'b0 : (sat_flag_q | acc_clip | (d2_q & res_sat));
        ovf_err_d  = layer_start ? 1'b0 : (ovf_err_q | drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_q         <= '0;
            v1_q         <= 1'b0;
            d1_q         <= 1'b0;
            d2_q         <= 1'b0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            addr_cnt_q   <= '0;
            target_q     <= '0;
            done_cnt_q   <= '0;
            stale_q      <= 1'b0;
            sat_flag_q   <= 1'b0;
            ovf_err_q    <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            p1_q         <= p1_d;
            v1_q         <= v1_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            addr_cnt_q   <= addr_cnt_d;
            target_q     <= target_d;
            done_cnt_q   <= done_cnt_d;
            stale_q      <= stale_d;
            sat_flag_q   <= sat_flag_d;
            ovf_err_q    <= ovf_err_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_addr   = out_addr_q;
    assign busy       = out_valid_q & ~out_ready;
    assign sat_flag   = sat_flag_q;
    assign ovf_err    = ovf_err_q;
    assign layer_done = layer_done_q;

endmodule

// File: tb/tb_neuron_mac_writeback.sv
// Scoreboard bench for neuron_mac_writeback: a RELU=1 instance is scored on every accepted
// result; a RELU=0 twin sharing the same stimulus is checked for the signed-result case.
module tb_neuron_mac_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        layer_start = 1'b0;
    logic [15:0] BaseAddr_out = '0;
    logic [15:0] total_output_neurons = '0;
    logic        PE_enable = 1'b0;
    logic [15:0] weight = '0;
    logic [15:0] in_data = '0;
    logic        neuron_done = 1'b0;
    logic        out_ready = 1'b0;

    logic        out_valid, busy, sat_flag, ovf_err, layer_done;
    logic [15:0] out_data, out_addr;
    logic        nr_valid, nr_busy, nr_sat, nr_ovf, nr_done;
    logic [15:0] nr_data, nr_addr;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   ld_count = 0;

    always #5 clk = ~clk;

    neuron_mac_writeback #(.RELU(1)) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .BaseAddr_out(BaseAddr_out),
        .total_output_neurons(total_output_neurons), .PE_enable(PE_enable), .weight(weight),
        .in_data(in_data), .neuron_done(neuron_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .busy(busy),
        .sat_flag(sat_flag), .ovf_err(ovf_err), .layer_done(layer_done)
    );

    neuron_mac_writeback #(.RELU(0)) dut_nr (
        .clk(clk), .rst(rst), .layer_start(layer_start), .BaseAddr_out(BaseAddr_out),
        .total_output_neurons(total_output_neurons), .PE_enable(PE_enable), .weight(weight),
        .in_data(in_data), .neuron_done(neuron_done), .out_valid(nr_valid),
        .out_ready(out_ready), .out_data(nr_data), .out_addr(nr_addr), .busy(nr_busy),
        .sat_flag(nr_sat), .ovf_err(nr_ovf), .layer_done(nr_done)
    );

    // Reference arithmetic: Q8.8 product sum, round half up, clip to 16 bits, optional ReLU.
    function automatic longint prod(input logic signed [15:0] a, input logic signed [15:0] b);
        return longint'(a) * longint'(b);
    endfunction

    function automatic logic [15:0] model(input longint acc, input bit relu);
        longint r;
        r = (acc + 128) >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[15:0];
    endfunction

    // Scoreboard side: every handshake pops and compares one expected result.
    always @(negedge clk) begin
        if (rst) begin
            if (layer_done) ld_count++;
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result got data=%h addr=%h, none expected",
                             out_data, out_addr);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_data !== mon_e.data || out_addr !== mon_e.addr) begin
                        miscompares++;
                        $display("FAIL result got data=%h addr=%h, expected data=%h addr=%h",
                                 out_data, out_addr, mon_e.data, mon_e.addr);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic [15:0] base, input logic [15:0] n);
        BaseAddr_out = base;
        total_output_neurons = n;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] w, input logic [15:0] x, input bit done);
        PE_enable = 1'b1;
        weight = w;
        in_data = x;
        neuron_done = done;
        tick();
        PE_enable = 1'b0;
        neuron_done = 1'b0;
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] a);
        sb.push_back('{data: d, addr: a});
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || layer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got valid=%b busy=%b done=%b, expected 0 0 0",
                     out_valid, busy, layer_done);
        end
        vectors++;
        if (out_data !== 16'h0 || out_addr !== 16'h0 || sat_flag !== 1'b0 || ovf_err !== 1'b0)
        begin
            miscompares++;
            $display("FAIL reset_data got data=%h addr=%h sat=%b ovf=%b, expected all 0",
                     out_data, out_addr, sat_flag, ovf_err);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int ld0;
        out_ready = 1'b0;
        start_layer(16'h0040, 16'd1);
        for (int i = 0; i < 4; i++) beat(16'h0100, 16'h0200, i == 3);
        push(model(4 * prod(16'sh0100, 16'sh0200), 1'b1), 16'h0040);
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early got out_valid=%b, expected 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 16'h0800 || out_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL basic_latency got valid=%b data=%h addr=%h, expected 1 0800 0040",
                     out_valid, out_data, out_addr);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy got %b, expected 1", busy);
        end
        ld0 = ld_count;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (layer_done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_layer_done got done=%b valid=%b, expected 1 0",
                     layer_done, out_valid);
        end
        tick();
        vectors++;
        if (ld_count !== ld0 + 1) begin
            miscompares++;
            $display("FAIL basic_done_pulses got %0d, expected %0d", ld_count - ld0, 1);
        end
    endtask

    task automatic test_sign_relu();
        bit ok;
        out_ready = 1'b1;
        start_layer(16'h0010, 16'd1);
        beat(16'hFF00, 16'h0300, 1'b1);
        push(model(prod(16'shFF00, 16'sh0300), 1'b1), 16'h0010);
        wait_valid(10, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL sign_timeout got out_valid=0, expected 1");
        end
        vectors++;
        if (nr_valid !== 1'b1 || nr_data !== model(prod(16'shFF00, 16'sh0300), 1'b0)) begin
            miscompares++;
            $display("FAIL sign_norelu got valid=%b data=%h, expected 1 fd00", nr_valid, nr_data);
        end
        drain(10);
        tick();
    endtask

    task automatic test_sat_round();
        bit ok;
        out_ready = 1'b1;
        start_layer(16'h0020, 16'd2);
        for (int i = 0; i < 4; i++) beat(16'h7FFF, 16'h7FFF, i == 3);
        push(16'h7FFF, 16'h0020);
        wait_valid(10, ok);
        vectors++;
        if (!ok || sat_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_flag got valid=%b sat=%b, expected 1 1", ok, sat_flag);
        end
        tick();
        beat(16'h0001, 16'h0080, 1'b1);
        push(model(prod(16'sh0001, 16'sh0080), 1'b1), 16'h0021);
        wait_valid(10, ok);
        tick();
        vectors++;
        if (!ok || layer_done !== 1'b1) begin
            miscompares++;
            $display("FAIL round_layer_done got valid=%b done=%b, expected 1 1", ok, layer_done);
        end
        start_layer(16'h0000, 16'd1);
        vectors++;
        if (sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear got %b, expected 0", sat_flag);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        start_layer(16'h0040, 16'd3);
        beat(16'h0100, 16'h0100, 1'b1);
        beat(16'h0200, 16'h0100, 1'b1);
        beat(16'h0300, 16'h0100, 1'b1);
        push(16'h0100, 16'h0040);
        tick();
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 16'h0040 || out_data !== 16'h0100) begin
            miscompares++;
            $display("FAIL bp_hold got valid=%b data=%h addr=%h, expected 1 0100 0040",
                     out_valid, out_data, out_addr);
        end
        vectors++;
        if (busy !== 1'b1 || ovf_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_flags got busy=%b ovf=%b, expected 1 1", busy, ovf_err);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (layer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_first_accept got layer_done=%b, expected 0", layer_done);
        end
        beat(16'h0400, 16'h0100, 1'b1);
        push(16'h0400, 16'h0041);
        wait_valid(10, ok);
        tick();
        vectors++;
        if (!ok || layer_done !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_second_accept got valid=%b done=%b, expected 1 0", ok, layer_done);
        end
        beat(16'h0500, 16'h0100, 1'b1);
        push(16'h0500, 16'h0042);
        wait_valid(10, ok);
        tick();
        vectors++;
        if (!ok || layer_done !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_third_accept got valid=%b done=%b, expected 1 1", ok, layer_done);
        end
    endtask

    task automatic test_back_to_back();
        int ld0;
        out_ready = 1'b1;
        start_layer(16'h0050, 16'd2);
        ld0 = ld_count;
        beat(16'h0100, 16'h0100, 1'b1);
        beat(16'h0200, 16'h0100, 1'b1);
        push(model(prod(16'sh0100, 16'sh0100), 1'b1), 16'h0050);
        push(model(prod(16'sh0200, 16'sh0100), 1'b1), 16'h0051);
        drain(20);
        tick();
        tick();
        vectors++;
        if (sb.size() != 0 || ld_count != ld0 + 1) begin
            miscompares++;
            $display("FAIL b2b_drain got pending=%0d pulses=%0d, expected 0 1",
                     sb.size(), ld_count - ld0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        start_layer(16'h0060, 16'd1);
        beat(16'h0100, 16'h0100, 1'b1);
        tick();
        tick();
        tick();
        PE_enable = 1'b1;
        weight = 16'h0100;
        in_data = 16'h0100;
        tick();
        weight = 16'h0200;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_addr !== 16'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got valid=%b data=%h addr=%h busy=%b, expected all 0",
                     out_valid, out_data, out_addr, busy);
        end
        PE_enable = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        start_layer(16'h0060, 16'd1);
        beat(16'h0100, 16'h0100, 1'b1);
        push(16'h0100, 16'h0060);
        wait_valid(10, ok);
        tick();
        vectors++;
        if (!ok || layer_done !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_recover got valid=%b done=%b, expected 1 1", ok, layer_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_relu();
        test_sat_round();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        tick();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
